input_debouncer: RTL and testbench

INPUT_DEBOUNCER -- requirements
Module: input_debouncer

---
 rtl/input_debouncer_if.sv | 41 ++++
 rtl/input_debouncer.sv | 130 +++++++++++++
 tb/tb_input_debouncer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// -----------------------------------------------------------------------------
// input_debouncer_if
//
// Purpose:
//   Bundles the four-channel raw/clean signal group of the input debouncer so
//   that the debouncer and whatever drives or consumes it share one handle.
//
// Signals:
//   Raw_In     [3:0]  asynchronous push-button/sensor levels
//                     (bit 0 Sensor, bit 1 Walk_Request, bit 2 Reprogram,
//                     bit 3 spare)
//   Clean_Out  [3:0]  debounced, clk-synchronous level per channel
//   Rise_Pulse [3:0]  one-cycle pulse when a Clean_Out bit goes 0->1
//   Fall_Pulse [3:0]  one-cycle pulse when a Clean_Out bit goes 1->0
//
// Modports:
//   master  the side that supplies Raw_In and consumes the debounced results
//   slave   the debouncer itself
// -----------------------------------------------------------------------------
interface input_debouncer_if;

    logic [3:0] Raw_In;
    logic [3:0] Clean_Out;
    logic [3:0] Rise_Pulse;
    logic [3:0] Fall_Pulse;

    modport master (
        output Raw_In,
        input  Clean_Out,
        input  Rise_Pulse,
        input  Fall_Pulse
    );

    modport slave (
        input  Raw_In,
        output Clean_Out,
        output Rise_Pulse,
        output Fall_Pulse
    );

endinterface

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Purpose:
//   Four fully independent debounce channels. Each raw level passes through a
//   two-flop synchronizer. A per-channel counter then measures how many
//   consecutive cycles the synchronized level has disagreed with the accepted
//   ("stable") level. When DEBOUNCE_COUNT consecutive disagreeing cycles have
//   been seen, the new level is accepted. A registered one-cycle rise or fall
//   pulse accompanies every accepted change.
//
// Parameters:
//   DEBOUNCE_COUNT  consecutive mismatch cycles needed to accept a new level
//                   (1 .. 2**CNT_WIDTH-1)
//   CNT_WIDTH       width of each per-channel counter
//
// Ports:
//   clk      sole clock, rising edge
//   Reset_n  asynchronous active-low reset; clears every flop immediately
//   bus      input_debouncer_if.slave
//              Raw_In     -> raw levels in
//              Clean_Out  <- debounced levels
//              Rise_Pulse <- 0->1 pulses
//              Fall_Pulse <- 1->0 pulses
//
// Timing:
//   A level first captured into the first synchronizer flop at edge E0 and then
//   held appears on Clean_Out at edge E0+DEBOUNCE_COUNT+1. Every output comes
//   straight from a flop.
// -----------------------------------------------------------------------------
module input_debouncer #(
    parameter int unsigned DEBOUNCE_COUNT = 50000,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                clk,
    input  logic                Reset_n,
    input_debouncer_if.slave    bus
);

    // Terminal count. The counter runs 0 .. DEBOUNCE_COUNT-1. Reaching this
    // value while still mismatched means DEBOUNCE_COUNT consecutive mismatch
    // cycles have elapsed.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_COUNT - 1);

    logic [3:0] clean_vec;
    logic [3:0] rise_vec;
    logic [3:0] fall_vec;

    // Each channel gets its own private copy of every register. Nothing inside
    // the generate body refers to another channel, so the channels cannot
    // interact.
    for (genvar ch = 0; ch < 4; ch++) begin : g_chan

        logic                 sync1;
        logic                 sync2;
        logic                 stable;
        logic [CNT_WIDTH-1:0] cnt;
        logic                 rise;
        logic                 fall;

        logic                 stable_next;
        logic [CNT_WIDTH-1:0] cnt_next;
        logic                 rise_next;
        logic                 fall_next;

        // Next-state logic for one channel.
        //
        // Agreement between sync2 and stable clears the counter. This single
        // rule also gives the "no partial credit" behaviour: any agreeing cycle
        // in the middle of a count restarts it from zero.
        //
        // On disagreement the counter advances. It stops at CNT_LAST, where
        // the new level is accepted, so it never exceeds CNT_LAST and never
        // wraps.
        //
        // The pulse registers are loaded on the same edge that changes stable.
        // As a result, each pulse is visible during exactly the cycle after
        // that edge. Because an acceptance always inverts stable, the
        // accepted level is ~stable, and only one of rise/fall can be set.
        always_comb begin
            stable_next = stable;
            cnt_next    = '0;
            rise_next   = 1'b0;
            fall_next   = 1'b0;

            if (sync2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable_next = sync2;
                    rise_next   = sync2;
                    fall_next   = ~sync2;
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end
        end

        // All per-channel state, including the two synchronizer flops, clears
        // asynchronously. Since rise/fall are simply forced to zero, a reset
        // can never produce a pulse.
        always_ff @(posedge clk or negedge Reset_n) begin
            if (!Reset_n) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                stable <= 1'b0;
                cnt    <= '0;
                rise   <= 1'b0;
                fall   <= 1'b0;
            end else begin
                sync1  <= bus.Raw_In[ch];
                sync2  <= sync1;
                stable <= stable_next;
                cnt    <= cnt_next;
                rise   <= rise_next;
                fall   <= fall_next;
            end
        end

        assign clean_vec[ch] = stable;
        assign rise_vec[ch]  = rise;
        assign fall_vec[ch]  = fall;

    end

    // Drive the interface outputs directly from the per-channel flops, with no
    // logic in between.
    assign bus.Clean_Out  = clean_vec;
    assign bus.Rise_Pulse = rise_vec;
    assign bus.Fall_Pulse = fall_vec;

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Purpose:
//   Self-checking bench for input_debouncer. Two instances share one raw input
//   vector: one built with DEBOUNCE_COUNT = 4 and one with DEBOUNCE_COUNT = 1.
//
//   The reference model works from the acceptance rule directly. It delays the
//   raw level by two edges to obtain the synchronized level. It then remembers
//   the synchronized levels seen at the most recent edges. A channel flips at
//   an edge when each of the last DEBOUNCE_COUNT of those levels disagrees
//   with the current accepted level.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

    logic       clk;
    logic       Reset_n;
    logic [3:0] raw;

    int checks;
    int errors;

    input_debouncer_if bus4 ();
    input_debouncer_if bus1 ();

    assign bus4.Raw_In = raw;
    assign bus1.Raw_In = raw;

    input_debouncer #(
        .DEBOUNCE_COUNT (4),
        .CNT_WIDTH      (16)
    ) dut4 (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus4)
    );

    input_debouncer #(
        .DEBOUNCE_COUNT (1),
        .CNT_WIDTH      (16)
    ) dut1 (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus1)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Index 0 models the DEBOUNCE_COUNT = 4 instance; index 1 models the
    // DEBOUNCE_COUNT = 1 instance.
    int unsigned m_depth [2] = '{4, 1};
    logic [3:0]  m_sync1 [2];
    logic [3:0]  m_sync2 [2];
    logic [3:0]  m_stable[2];
    logic [3:0]  m_rise  [2];
    logic [3:0]  m_fall  [2];
    logic [3:0]  m_hist  [2][4];
    int          m_fill  [2];

    function automatic void modelReset();
        for (int d = 0; d < 2; d++) begin
            m_sync1[d]  = '0;
            m_sync2[d]  = '0;
            m_stable[d] = '0;
            m_rise[d]   = '0;
            m_fall[d]   = '0;
            m_fill[d]   = 0;
            for (int k = 0; k < 4; k++) m_hist[d][k] = '0;
        end
    endfunction

    // Advance the model by one rising edge, using the raw level that was
    // present just before that edge.
    function automatic void modelEdge(input logic [3:0] raw_now);
        for (int d = 0; d < 2; d++) begin
            for (int k = 3; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
            m_hist[d][0] = m_sync2[d];
            if (m_fill[d] < 4) m_fill[d]++;
            m_rise[d] = '0;
            m_fall[d] = '0;
            for (int ch = 0; ch < 4; ch++) begin
                bit accept;
                accept = (m_fill[d] >= int'(m_depth[d]));
                for (int k = 0; k < int'(m_depth[d]); k++)
                    if (m_hist[d][k][ch] == m_stable[d][ch]) accept = 1'b0;
                if (accept) begin
                    m_stable[d][ch] = ~m_stable[d][ch];
                    if (m_stable[d][ch]) m_rise[d][ch] = 1'b1;
                    else                 m_fall[d][ch] = 1'b1;
                end
            end
            m_sync2[d] = m_sync1[d];
            m_sync1[d] = raw_now;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%b expected=%b at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, " n4 clean"}, bus4.Clean_Out,  m_stable[0]);
        checkOutput({tag, " n4 rise"},  bus4.Rise_Pulse, m_rise[0]);
        checkOutput({tag, " n4 fall"},  bus4.Fall_Pulse, m_fall[0]);
        checkOutput({tag, " n4 rise&fall"}, bus4.Rise_Pulse & bus4.Fall_Pulse, 4'b0000);
        checkOutput({tag, " n1 clean"}, bus1.Clean_Out,  m_stable[1]);
        checkOutput({tag, " n1 rise"},  bus1.Rise_Pulse, m_rise[1]);
        checkOutput({tag, " n1 fall"},  bus1.Fall_Pulse, m_fall[1]);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " n4 clean"}, bus4.Clean_Out,  4'b0000);
        checkOutput({tag, " n4 rise"},  bus4.Rise_Pulse, 4'b0000);
        checkOutput({tag, " n4 fall"},  bus4.Fall_Pulse, 4'b0000);
        checkOutput({tag, " n1 clean"}, bus1.Clean_Out,  4'b0000);
        checkOutput({tag, " n1 rise"},  bus1.Rise_Pulse, 4'b0000);
        checkOutput({tag, " n1 fall"},  bus1.Fall_Pulse, 4'b0000);
    endtask

    // Apply one raw value for one full cycle. The value is driven from a
    // falling edge, sampled at the next rising edge (the model steps in lock
    // step), and the outputs are checked 1 unit after that edge.
    task automatic applyStimulus(input logic [3:0] r, input string tag);
        raw = r;
        @(posedge clk);
        modelEdge(r);
        #1;
        compareAll(tag);
        @(negedge clk);
    endtask

    task automatic holdFor(input logic [3:0] r, input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(r, tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] rnd;
        int         pulse_cnt;
        logic       seen_high;

        checks  = 0;
        errors  = 0;
        raw     = 4'b0000;
        Reset_n = 1'b0;
        modelReset();

        // Reset state, observed while reset is held across a rising edge.
        @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        Reset_n = 1'b1;

        // Walk_Request rises: latency of exactly E0+5 and a single pulse.
        $display("[TB] latency on channel 1");
        for (int k = 0; k <= 6; k++) begin
            applyStimulus(4'b0010, "latency");
            if (k == 4) checkOutput("latency e4 clean", bus4.Clean_Out, 4'b0000);
            if (k == 5) begin
                checkOutput("latency e5 clean", bus4.Clean_Out,  4'b0010);
                checkOutput("latency e5 rise",  bus4.Rise_Pulse, 4'b0010);
            end
            if (k == 6) checkOutput("latency e6 rise", bus4.Rise_Pulse, 4'b0000);
        end
        holdFor(4'b0000, 8, "latency release");

        // Sensor high for only three cycles: rejected by the DEBOUNCE_COUNT=4 instance.
        $display("[TB] short glitch on channel 0");
        seen_high = 1'b0;
        for (int k = 0; k < 11; k++) begin
            applyStimulus((k < 3) ? 4'b0001 : 4'b0000, "glitch");
            if (bus4.Clean_Out[0] || bus4.Rise_Pulse[0]) seen_high = 1'b1;
        end
        checkOutput("glitch rejected", {3'b000, seen_high}, 4'b0000);

        // Bounce on Reprogram: 1,1,1,0 then a steady 1 gives a single accepted rise.
        $display("[TB] bounce on channel 2");
        pulse_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            applyStimulus((k == 3) ? 4'b0000 : 4'b0100, "bounce");
            if (bus4.Rise_Pulse[2]) pulse_cnt++;
        end
        checkOutput("bounce rise count", 4'(pulse_cnt), 4'd1);
        holdFor(4'b0000, 8, "bounce release");

        // All four channels fall together.
        $display("[TB] simultaneous fall");
        holdFor(4'b1111, 8, "all high");
        pulse_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0000, "all fall");
            if (bus4.Fall_Pulse == 4'b1111) pulse_cnt++;
        end
        checkOutput("all fall count", 4'(pulse_cnt), 4'd1);
        checkOutput("all fall clean", bus4.Clean_Out, 4'b0000);

        // Async reset mid-count while channel 3 is clean-high.
        $display("[TB] async reset mid-count");
        holdFor(4'b1000, 8, "ch3 high");
        holdFor(4'b0000, 2, "ch3 counting");
        #2;
        Reset_n = 1'b0;
        #1;
        checkAllZero("async reset");
        modelReset();
        @(negedge clk);
        @(negedge clk);
        Reset_n = 1'b1;
        holdFor(4'b0000, 8, "post reset quiet");

        // Input already high while reset is released.
        $display("[TB] input high across reset release");
        Reset_n = 1'b0;
        raw     = 4'b0100;
        #1;
        modelReset();
        @(negedge clk);
        Reset_n = 1'b1;
        holdFor(4'b0100, 8, "high at release");
        holdFor(4'b0000, 8, "high at release drop");

        // Single-cycle pulse on the DEBOUNCE_COUNT=1 instance: rise at E0+2.
        $display("[TB] single-cycle pulse, count 1");
        for (int k = 0; k <= 4; k++) begin
            applyStimulus((k == 0) ? 4'b0001 : 4'b0000, "n1 pulse");
            if (k == 1) checkOutput("n1 e1 clean", bus1.Clean_Out, 4'b0000);
            if (k == 2) begin
                checkOutput("n1 e2 clean", bus1.Clean_Out,  4'b0001);
                checkOutput("n1 e2 rise",  bus1.Rise_Pulse, 4'b0001);
            end
        end

        // Randomized traffic: alternating bouncy and calm phases.
        $display("[TB] random traffic");
        rnd = 4'b0000;
        for (int k = 0; k < 800; k++) begin
            for (int b = 0; b < 4; b++) begin
                if ((k / 100) % 2 == 0) begin
                    if ($urandom_range(0, 1) == 0) rnd[b] = ~rnd[b];
                end else begin
                    if ($urandom_range(0, 6) == 0) rnd[b] = ~rnd[b];
                end
            end
            applyStimulus(rnd, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
